// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - shared constants, lane index type and pointer helper for mux4_to_1_arb
package mux4_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Lane after x, wrapping 3 -> 0 through the natural 2-bit overflow
  function automatic sel_t next_ptr(input sel_t x);
    return x + sel_t'(1);
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - combinational 4-way arbiter, round-robin or fixed priority (MUX4_FIXED_PRIO_EN)
module rr_arb4
  import mux4_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  sel_t              ptr,
  output logic [CH_NUM-1:0] grant,
  output sel_t              grant_idx,
  output logic              any
);

`ifndef MUX4_FIXED_PRIO_EN
  sel_t cand;
`endif

  // Pick the winning lane; the scan runs from the lowest priority up so the
  // last hit left standing is the highest-priority requester
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
`ifdef MUX4_FIXED_PRIO_EN
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = sel_t'(i);
        any       = 1'b1;
      end
    end
`else
    cand = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        grant_idx = cand;
        any       = 1'b1;
      end
    end
`endif
    if (any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mux4_to_1_arb.sv
// rtl/mux4_to_1_arb.sv - 4-to-1 stream merger with registered output; MUX4_FIXED_PRIO_EN selects fixed priority
module mux4_to_1_arb
  import mux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             v0,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  output logic             r0,
  output logic             r1,
  output logic             r2,
  output logic             r3,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       y_sel,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  y_q, y_d;
  sel_t              y_sel_q, y_sel_d;
  sel_t              arb_ptr;
  logic [CH_NUM-1:0] req;
  logic [CH_NUM-1:0] grant;
  sel_t              grant_idx;
  logic              any;
  logic              load;
  logic              accept;
  logic [WIDTH-1:0]  d_g;

  assign req     = {v3, v2, v1, v0};
  assign y       = y_q;
  assign y_sel   = y_sel_q;
  assign y_valid = (state_q == ST_FULL);

  // Output slot can take a word when empty or when it is draining this edge
  assign load   = (state_q == ST_EMPTY) || y_ready;
  assign accept = load && any;

  rr_arb4 u_arb (
    .req       (req),
    .ptr       (arb_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Ready goes only to the winner, and never while reset is asserted
  always_comb begin
    r0 = rst_n && load && grant[0];
    r1 = rst_n && load && grant[1];
    r2 = rst_n && load && grant[2];
    r3 = rst_n && load && grant[3];
  end

  // Select the winning lane's data
  always_comb begin
    d_g = d0;
    case (grant_idx)
      2'd0:    d_g = d0;
      2'd1:    d_g = d1;
      2'd2:    d_g = d2;
      default: d_g = d3;
    endcase
  end

  // Output stage next state: load on accept, empty on drain, hold otherwise
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    y_sel_d = y_sel_q;
    if (accept) begin
      y_d     = d_g;
      y_sel_d = grant_idx;
    end
    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (accept)       state_d = ST_FULL;
        else if (y_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output register; y and y_sel keep their last word after a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      y_sel_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      y_sel_q <= y_sel_d;
    end
  end

`ifdef MUX4_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  sel_t ptr_q, ptr_d;

  // Round-robin pointer moves just past the lane that won
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = next_ptr(grant_idx);
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`endif

endmodule

// File: tb/tb_mux4_to_1_arb.sv
// tb/tb_mux4_to_1_arb.sv - scoreboard bench for mux4_to_1_arb
module tb_mux4_to_1_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d [4];
  logic [3:0] v = 4'b0;
  logic       y_ready = 1'b0;
  logic       r0, r1, r2, r3;
  logic [7:0] y;
  logic [1:0] y_sel;
  logic       y_valid;
  logic [3:0] rvec;

  int checks = 0;
  int failures = 0;

  logic [9:0] sb [$];
  int         mptr = 0;
  bit         m_found;
  int         m_g;
  bit         m_load;
  logic [3:0] m_r;

  assign rvec = {r3, r2, r1, r0};

  always #5 clk = ~clk;

  mux4_to_1_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .v0(v[0]), .v1(v[1]), .v2(v[2]), .v3(v[3]),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .y(y), .y_sel(y_sel), .y_valid(y_valid), .y_ready(y_ready)
  );

  // Reference model and scoreboard, evaluated on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mptr = 0;
    end else begin
      checks++;
      if (y_valid !== (sb.size() != 0)) begin
        failures++;
        $display("FAIL sb_valid: got %b expected %b", y_valid, sb.size() != 0);
      end
      if (sb.size() != 0) begin
        checks++;
        if ({y_sel, y} !== sb[0]) begin
          failures++;
          $display("FAIL sb_word: got sel=%0d y=%h expected sel=%0d y=%h",
                   y_sel, y, sb[0][9:8], sb[0][7:0]);
        end
      end
      m_load  = (sb.size() == 0) || y_ready;
      m_found = 1'b0;
      m_g     = 0;
      for (int k = 0; k < 4; k++) begin
        if (!m_found && v[(mptr + k) % 4]) begin
          m_found = 1'b1;
          m_g     = (mptr + k) % 4;
        end
      end
      m_r = (m_load && m_found) ? (4'b0001 << m_g) : 4'b0000;
      checks++;
      if (rvec !== m_r) begin
        failures++;
        $display("FAIL sb_ready: got %b expected %b", rvec, m_r);
      end
      if (sb.size() != 0 && y_ready) void'(sb.pop_front());
      if (m_load && m_found) begin
        sb.push_back({m_g[1:0], d[m_g]});
`ifndef MUX4_FIXED_PRIO_EN
        mptr = (m_g + 1) % 4;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v = 4'b0;
    y_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    v = 4'hF;
    #1;
    checks++;
    if ({y_valid, y, y_sel, rvec} !== 15'h0) begin
      failures++;
      $display("FAIL reset_init: got v=%b y=%h sel=%0d r=%b expected all zero", y_valid, y, y_sel, rvec);
    end
    v = 4'b0;
    tick();
    rst_n = 1'b1;
    y_ready = 1'b0;
    d[0] = 8'h3C;
    v = 4'b0001;
    tick();
    v = 4'b0000;
    checks++;
    if (y_valid !== 1'b1 || y !== 8'h3C) begin
      failures++;
      $display("FAIL reset_setup: got v=%b y=%h expected 1 3c", y_valid, y);
    end
    tick();
    v = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({y_valid, y, y_sel, rvec} !== 15'h0) begin
      failures++;
      $display("FAIL reset_async: got v=%b y=%h sel=%0d r=%b expected all zero", y_valid, y, y_sel, rvec);
    end
    tick();
    tick();
    checks++;
    if (rvec !== 4'b0) begin
      failures++;
      $display("FAIL reset_ready_held: got %b expected 0000", rvec);
    end
    for (int i = 0; i < 4; i++) d[i] = 8'h50 + 8'(i);
    y_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (y_valid !== 1'b1 || y_sel !== 2'd0 || y !== 8'h50) begin
      failures++;
      $display("FAIL reset_first_sel: got v=%b sel=%0d y=%h expected 1 0 50", y_valid, y_sel, y);
    end
    v = 4'b0;
    tick();
    tick();
  endtask

  task automatic test_single_lane();
    v = 4'b0;
    y_ready = 1'b1;
    tick();
    d[2] = 8'hA5;
    v = 4'b0100;
    #1;
    checks++;
    if (rvec !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready: got %b expected 0100", rvec);
    end
    tick();
    v = 4'b0;
    checks++;
    if (y !== 8'hA5 || y_sel !== 2'd2 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_out: got y=%h sel=%0d v=%b expected a5 2 1", y, y_sel, y_valid);
    end
    tick();
    checks++;
    if (y_valid !== 1'b0 || y !== 8'hA5 || y_sel !== 2'd2) begin
      failures++;
      $display("FAIL single_drain: got v=%b y=%h sel=%0d expected 0 a5 2", y_valid, y, y_sel);
    end
  endtask

  task automatic test_fairness();
    int exp_sel;
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
    v = 4'hF;
    for (int n = 0; n < 6; n++) begin
      tick();
`ifdef MUX4_FIXED_PRIO_EN
      exp_sel = 0;
`else
      exp_sel = n % 4;
`endif
      checks++;
      if (y_valid !== 1'b1 || y_sel !== exp_sel[1:0] || y !== 8'h10 + 8'(exp_sel)) begin
        failures++;
        $display("FAIL fair_%0d: got v=%b sel=%0d y=%h expected 1 %0d %h",
                 n, y_valid, y_sel, y, exp_sel, 8'h10 + 8'(exp_sel));
      end
    end
    v = 4'b0;
    tick();
    tick();
  endtask

`ifndef MUX4_FIXED_PRIO_EN
  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'h20 + 8'(i);
    v = 4'hF;
    tick();
    tick();
    y_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (y !== 8'h21 || y_sel !== 2'd1 || y_valid !== 1'b1 || rvec !== 4'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: got y=%h sel=%0d v=%b r=%b expected 21 1 1 0000",
                 n, y, y_sel, y_valid, rvec);
      end
      tick();
    end
    y_ready = 1'b1;
    #1;
    checks++;
    if (rvec !== 4'b0100) begin
      failures++;
      $display("FAIL bp_release_ready: got %b expected 0100", rvec);
    end
    tick();
    v = 4'b0;
    checks++;
    if (y !== 8'h22 || y_sel !== 2'd2 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got y=%h sel=%0d v=%b expected 22 2 1", y, y_sel, y_valid);
    end
    tick();
    tick();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'h40 + 8'(i);
    v = 4'b0100;
    tick();
    v = 4'b0010;
    #1;
    checks++;
    if (rvec !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_ready: got %b expected 0010", rvec);
    end
    tick();
    v = 4'b0101;
    checks++;
    if (y_sel !== 2'd1 || y !== 8'h41) begin
      failures++;
      $display("FAIL wrap_out: got sel=%0d y=%h expected 1 41", y_sel, y);
    end
    #1;
    checks++;
    if (rvec !== 4'b0100) begin
      failures++;
      $display("FAIL skip_ready: got %b expected 0100", rvec);
    end
    tick();
    v = 4'b0;
    checks++;
    if (y_sel !== 2'd2 || y !== 8'h42) begin
      failures++;
      $display("FAIL skip_out: got sel=%0d y=%h expected 2 42", y_sel, y);
    end
    tick();
    tick();
  endtask
`else
  task automatic test_fixed_prio();
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = 8'h60 + 8'(i);
    v = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (y_sel !== 2'd0 || y_valid !== 1'b1) begin
        failures++;
        $display("FAIL fixed_hold_%0d: got sel=%0d v=%b expected 0 1", n, y_sel, y_valid);
      end
    end
    v = 4'b1000;
    tick();
    v = 4'b0;
    checks++;
    if (y_sel !== 2'd3 || y !== 8'h63) begin
      failures++;
      $display("FAIL fixed_lane3: got sel=%0d y=%h expected 3 63", y_sel, y);
    end
    tick();
    tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      v = 4'($urandom);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      y_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    v = 4'b0;
    y_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (sb.size() != 0 || y_valid !== 1'b0) begin
      failures++;
      $display("FAIL random_drain: got pending=%0d v=%b expected 0 0", sb.size(), y_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_fairness();
`ifndef MUX4_FIXED_PRIO_EN
    test_backpressure();
    test_wrap_skip();
`else
    test_fixed_prio();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_to_1_arb.md
Name: mux4_to_1_arb

Overview:
- Four-input to one-output stream merger with round-robin arbitration and a registered output stage.
- It is the collecting counterpart of the 1-to-4 demux. Each accepted word leaves tagged with a 2-bit channel index (`y_sel`, bit0 = s0, bit1 = s1), so a demux driven by `y_sel` routes it back to the same lane.
- It sits between four producer lanes and a single shared consumer.

Parameters:
- WIDTH, 8, data width of each input lane and of the output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- d0..d3  input  WIDTH each  lane data
- v0..v3  input  1 each  lane valid
- r0..r3  output  1 each  lane ready; combinational
- y  output  WIDTH  merged data, registered
- y_sel  output  2  source lane of y, registered
- y_valid  output  1  output valid, registered
- y_ready  input  1  consumer ready

Behaviour:
- Reset (async assert, sync release): y_valid=0, y=0, y_sel=0, round-robin pointer ptr=0. All r0..r3 are 0 while rst_n=0.
- States (equal to y_valid):
  - EMPTY (y_valid=0).
  - FULL (y_valid=1).
- Output transfer: occurs on an edge where y_valid && y_ready.
- load = !y_valid || y_ready (output slot is free or is being freed this cycle).
- Arbitration:
  - Requests are v0..v3.
  - Search starts at lane ptr and proceeds ptr, ptr+1, … mod 4; the first requesting lane wins (lane g).
  - At most one r_i is high: r_g = load && v_g, all others 0.
  - r_i depends on v*, y_valid, y_ready and ptr. v_i must not depend on r_i.
- Accept (load && any v):
  - On the edge: y<=d_g, y_sel<=g, y_valid<=1, ptr<=(g+1) mod 4 (lane 3 wraps to 0).
  - Latency is 1 cycle from accept to y_valid.
- Simultaneous output transfer and accept:
  - Both occur on the same edge; FULL stays FULL.
  - Throughput is 1 word/cycle.
- Output transfer with no request: y_valid<=0; y and y_sel hold their last values; ptr unchanged.
- Backpressure (FULL, y_ready=0):
  - y, y_sel and y_valid are held stable.
  - All r_i = 0; ptr is held.
- No request in EMPTY: nothing changes.
- A lane keeping v high after its grant waits for the others. Worst-case wait while output drains every cycle: 3 transfers.
- Reset mid-operation: the held word is discarded, y_valid drops immediately, ptr returns to 0.
- Transitions:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on transfer without accept.
  - FULL → FULL on hold, or on transfer with accept.

Optional Feature:
- MUX4_FIXED_PRIO_EN defined:
  - Round-robin is replaced by fixed priority, lane 0 highest, then 1, 2, 3.
  - ptr is not implemented.
  - A continuously valid lower lane can starve.
- Undefined: round-robin as above.
- Ports and latency are identical in both builds.

Decomposition:
- Package mux4_pkg:
  - CH_NUM=4, SEL_W=2.
  - typedef sel_t (logic [SEL_W-1:0]).
  - Function next_ptr(sel_t) returning (x+1) mod 4.
- Sub-module rr_arb4:
  - Pure combinational.
  - Inputs req[3:0], ptr; outputs grant one-hot [3:0], grant_idx (sel_t), any.
  - Fixed-priority path selected by MUX4_FIXED_PRIO_EN inside it.
- Top level holds the output register, ptr register and ready gating.

Test Plan:
- Reset: drop rst_n mid-cycle while FULL with y=8'h3C → y_valid=0, y=0, y_sel=0 immediately. r0..r3=0 until release. After release with v0..v3 high, first y_sel=0.
- Single lane: v2=1, d2=8'hA5, y_ready=1 → r2=1 that cycle. Next edge: y=8'hA5, y_sel=2, y_valid=1. Lane drops v2 → y_valid=0 one edge later.
- Fairness: v0..v3 held 1, d_i=8'h10+i, y_ready=1 → y_sel sequence 0,1,2,3,0,1 on consecutive cycles, y=10,11,12,13,10,11, no bubbles.
- Backpressure: FULL with y_sel=1 and y_ready=0 for 3 cycles, v0..v3 high → y, y_sel stable, r0..r3=0. Raise y_ready → same edge transfers lane 1's word and loads lane 2.
- Wrap/skip: ptr=3, only v1 high → lane 1 wins, next ptr=2. Then v0 and v2 high → lane 2 wins first.
- With MUX4_FIXED_PRIO_EN: v0 and v3 held high for 4 cycles → y_sel=0 every cycle. Drop v0 → y_sel=3 next cycle.
